// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared external multiplier and divider behind the RV32M paths.
// Latches one request, drives operand magnitudes for a fixed latency, then sign-corrects the result.
module muldiv_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 1,
  parameter int DIV_LAT = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  output logic                 stall,
  output logic                 resp_valid,
  output logic [WIDTH-1:0]     resp_data,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_p,
  output logic [WIDTH-1:0]     div_numer,
  output logic [WIDTH-1:0]     div_denom,
  input  logic [WIDTH-1:0]     div_quot,
  input  logic [WIDTH-1:0]     div_rem
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [5:0]       cnt;
  logic [2:0]       op_q;
  logic             neg_q;
  logic             special_q;
  logic [WIDTH-1:0] special_res;

  logic             a_signed, b_signed, neg_a, neg_b;
  logic             is_div, div_zero, div_ovf, special, neg_res;
  logic [WIDTH-1:0] mag_a, mag_b, special_val;
  logic [5:0]       lat;

  // Request decode: operand signedness, magnitudes, result sign and the
  // divide cases that are answered without the divider.
  always_comb begin
    is_div   = req_op[2];
    a_signed = (req_op == 3'd1) || (req_op == 3'd2) || (req_op == 3'd4) || (req_op == 3'd6);
    b_signed = (req_op == 3'd1) || (req_op == 3'd4) || (req_op == 3'd6);
    neg_a    = a_signed && req_a[WIDTH-1];
    neg_b    = b_signed && req_b[WIDTH-1];
    mag_a    = neg_a ? -req_a : req_a;
    mag_b    = neg_b ? -req_b : req_b;
    div_zero = is_div && (req_b == '0);
    div_ovf  = is_div && !req_op[0] && (req_a == MIN_INT) && (req_b == '1);
    special  = div_zero || div_ovf;
    if (div_zero)
      special_val = req_op[1] ? req_a : '1;
    else
      special_val = req_op[1] ? '0 : MIN_INT;
    // Remainders follow the dividend; everything else follows the sign product.
    neg_res  = (is_div && req_op[1]) ? neg_a : (neg_a ^ neg_b);
    lat      = is_div ? 6'(DIV_LAT) : 6'(MUL_LAT);
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, remd, result;

  always_comb begin
    prod = neg_q ? -mul_p : mul_p;
    quot = neg_q ? -div_quot : div_quot;
    remd = neg_q ? -div_rem : div_rem;
    case (op_q)
      3'd0:             result = prod[WIDTH-1:0];
      3'd1, 3'd2, 3'd3: result = prod[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:       result = quot;
      default:          result = remd;
    endcase
    if (special_q)
      result = special_res;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      special_q   <= 1'b0;
      special_res <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      div_numer   <= '0;
      div_denom   <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q        <= req_op;
            neg_q       <= neg_res;
            special_q   <= special;
            special_res <= special_val;
            if (is_div) begin
              div_numer <= mag_a;
              div_denom <= mag_b;
            end else begin
              mul_a <= mag_a;
              mul_b <= mag_b;
            end
            if (special) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt   <= lat;
              state <= (lat == 6'd0) ? DONE : WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1)
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The external units are sampled directly in DONE, so a latency of 0 means
  // a purely combinational unit and the strobe still lands at acceptance+LAT+1.
  assign req_ready  = (state == IDLE);
  assign stall      = ((state == IDLE) && req_valid) || (state == WAIT);
  assign resp_valid = (state == DONE) && !flush;
  assign resp_data  = resp_valid ? result : '0;

endmodule
